// File: rtl/dlatch_exerciser_if.sv
// dlatch_exerciser_if
// Bundles the exerciser's run control, status and latch-side signals.
//   start      : run request (level-sampled)
//   d_out/e_out: drive latch d/e
//   q_in/q_bar_in : observed latch q/q_bar
//   busy/done/pass/err_count/vec_idx : run status
// Modports: slave = exerciser side, master = environment side
// (controller plus the latch under test).
interface dlatch_exerciser_if;
   logic       start;
   logic       d_out;
   logic       e_out;
   logic       q_in;
   logic       q_bar_in;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [1:0] vec_idx;

   modport slave (
      input  start, q_in, q_bar_in,
      output d_out, e_out, busy, done, pass, err_count, vec_idx
   );

   modport master (
      output start, q_in, q_bar_in,
      input  d_out, e_out, busy, done, pass, err_count, vec_idx
   );
endinterface

// File: rtl/dlatch_exerciser.sv
// dlatch_exerciser
// Clocked stimulus/monitor wrapped around a D latch. Sweeps every {e,d}
// combination, holding each for HOLD_CYCLES clocks, and checks q/q_bar
// against a reference model on the last clock of each hold window.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dlatch_exerciser_if.slave (start, d_out, e_out, q_in,
//           q_bar_in, busy, done, pass, err_count, vec_idx)
// Parameters:
//   HOLD_CYCLES (>=2) clocks per vector, NUM_PASSES (>=1) sweeps per run.
// Build option:
//   DLATCH_EXER_GRAY_EN defined -> Gray sweep order 00,01,11,10;
//   undefined -> binary order 00,01,10,11.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | after reset; latch inputs low, waiting for start
// S_RUN  | sweep in progress; vector held, sampled on last hold clock
// S_DONE | run finished; result held until the next start
module dlatch_exerciser #(
   parameter int HOLD_CYCLES = 10,
   parameter int NUM_PASSES  = 1
) (
   input logic               clk,
   input logic               rst_n,
   dlatch_exerciser_if.slave bus
);

   localparam int HW = $clog2(HOLD_CYCLES);
   localparam int PW = $clog2(NUM_PASSES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASSES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]    vec_idx_q, vec_idx_d;
   logic [PW-1:0] pass_cnt_q, pass_cnt_d;
   logic          exp_q_q, exp_q_d;
   logic          exp_valid_q, exp_valid_d;
   logic [7:0]    err_q, err_d;
   logic          pass_q, pass_d;

   logic [1:0]    cur_vec;
   logic          running;
   logic          sample;
   logic          expect_bit;
   logic          mismatch;

   // Vector bit 1 is e, bit 0 is d.
   function automatic logic [1:0] vec_of(input logic [1:0] idx);
`ifdef DLATCH_EXER_GRAY_EN
      return {idx[1], idx[1] ^ idx[0]};
`else
      return idx;
`endif
   endfunction

   assign cur_vec    = vec_of(vec_idx_q);
   assign running    = (state_q == S_RUN);
   assign sample     = running && (hold_cnt_q == HOLD_LAST);
   assign expect_bit = cur_vec[1] ? cur_vec[0] : exp_q_q;

   // Case-inequality so an undriven or X latch output counts as a fault.
   // Both failure conditions together still count as one mismatch.
   assign mismatch = (cur_vec[1] || exp_valid_q) &&
                     ((bus.q_in !== expect_bit) || (bus.q_bar_in !== ~bus.q_in));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         hold_cnt_q  <= '0;
         vec_idx_q   <= '0;
         pass_cnt_q  <= '0;
         exp_q_q     <= 1'b0;
         exp_valid_q <= 1'b0;
         err_q       <= '0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         vec_idx_q   <= vec_idx_d;
         pass_cnt_q  <= pass_cnt_d;
         exp_q_q     <= exp_q_d;
         exp_valid_q <= exp_valid_d;
         err_q       <= err_d;
         pass_q      <= pass_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      vec_idx_d   = vec_idx_q;
      pass_cnt_d  = pass_cnt_q;
      exp_q_d     = exp_q_q;
      exp_valid_d = exp_valid_q;
      err_d       = err_q;
      pass_d      = pass_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d     = S_RUN;
               hold_cnt_d  = '0;
               vec_idx_d   = '0;
               pass_cnt_d  = '0;
               exp_q_d     = 1'b0;
               exp_valid_d = 1'b0;
               err_d       = '0;
               pass_d      = 1'b0;
            end
         end
         S_RUN: begin
            if (sample) begin
               if (mismatch && (err_q != 8'hFF)) begin
                  err_d = err_q + 8'd1;
               end
               if (cur_vec[1]) begin
                  exp_q_d     = cur_vec[0];
                  exp_valid_d = 1'b1;
               end
               hold_cnt_d = '0;
               if (vec_idx_q == 2'd3) begin
                  vec_idx_d  = '0;
                  pass_cnt_d = pass_cnt_q + 1'b1;
                  if (pass_cnt_q == PASS_LAST) begin
                     state_d = S_DONE;
                     // err_d already includes this final sample.
                     pass_d  = (err_d == 8'd0);
                  end
               end else begin
                  vec_idx_d = vec_idx_q + 2'd1;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.e_out     = running ? cur_vec[1] : 1'b0;
   assign bus.d_out     = running ? cur_vec[0] : 1'b0;
   assign bus.busy      = running;
   assign bus.done      = (state_q == S_DONE);
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_dlatch_exerciser.sv
module tb_dlatch_exerciser;

   localparam int HA = 10;
   localparam int PA = 1;

   logic clk      = 1'b0;
   logic rst_n_a  = 1'b0;
   logic rst_n_bc = 1'b0;

   always #5 clk = ~clk;

   dlatch_exerciser_if ifa ();
   dlatch_exerciser_if ifb ();
   dlatch_exerciser_if ifc ();

   dlatch_exerciser #(.HOLD_CYCLES(HA), .NUM_PASSES(PA)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .bus(ifa.slave));
   dlatch_exerciser #(.HOLD_CYCLES(10), .NUM_PASSES(2)) dut_b (
      .clk(clk), .rst_n(rst_n_bc), .bus(ifb.slave));
   dlatch_exerciser #(.HOLD_CYCLES(2), .NUM_PASSES(100)) dut_c (
      .clk(clk), .rst_n(rst_n_bc), .bus(ifc.slave));

`ifdef DLATCH_EXER_GRAY_EN
   int order [4] = '{0, 1, 3, 2};
`else
   int order [4] = '{0, 1, 2, 3};
`endif

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Latch under test: ideal behaviour plus selectable faults.
   // fmode: 0 ideal, 1 q stuck 0, 2 q_bar tied to q, 3 random noise.
   int   fmode = 0;
   logic lat_q = 1'b0;
   logic nq = 1'b0, nqb = 1'b1;

   always @(ifa.e_out or ifa.d_out) if (ifa.e_out) lat_q = ifa.d_out;
   always @(negedge clk) begin
      nq  = 1'($urandom % 2);
      nqb = 1'($urandom % 2);
   end

   assign ifa.q_in     = (fmode == 1) ? 1'b0 : (fmode == 3) ? nq : lat_q;
   assign ifa.q_bar_in = (fmode == 2) ? ifa.q_in : (fmode == 3) ? nqb : ~ifa.q_in;

   // Behavioural model: a run is 4*HA*PA clocks counted from the start edge;
   // clock t of the run shows sweep step t/HA, and the last clock of each
   // window is the check point.
   bit m_act = 0, m_done = 0, m_expq = 0, m_expv = 0;
   int m_t = 0, m_err = 0;
   int m_v;
   bit m_e, m_d;

   always @(posedge clk or negedge rst_n_a) begin
      if (!rst_n_a) begin
         m_act = 0; m_done = 0; m_t = 0; m_err = 0; m_expv = 0; m_expq = 0;
      end else if (!m_act) begin
         if (ifa.start) begin
            m_act = 1; m_done = 0; m_t = 0; m_err = 0; m_expv = 0; m_expq = 0;
         end
      end else begin
         m_v = order[(m_t / HA) % 4];
         m_e = m_v[1];
         m_d = m_v[0];
         if ((m_t % HA) == HA - 1) begin
            if ((m_e || m_expv) &&
                ((ifa.q_in !== (m_e ? m_d : m_expq)) || (ifa.q_bar_in !== ~ifa.q_in)))
               m_err++;
            if (m_e) begin m_expq = m_d; m_expv = 1; end
         end
         m_t++;
         if (m_t == 4 * HA * PA) begin m_act = 0; m_done = 1; end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      int ev;
      int es;
      ev = m_act ? order[(m_t / HA) % 4] : 0;
      es = (m_err > 255) ? 255 : m_err;
      chk("busy", int'(ifa.busy), int'(m_act));
      chk("done", int'(ifa.done), int'(m_done));
      chk("pass", int'(ifa.pass), int'(m_done && m_err == 0));
      chk("err_count", int'(ifa.err_count), es);
      chk("vec_idx", int'(ifa.vec_idx), m_act ? (m_t / HA) % 4 : 0);
      chk("e_out", int'(ifa.e_out), (ev >> 1) & 1);
      chk("d_out", int'(ifa.d_out), ev & 1);
   end

   int vseq [$];
   int busy_gap;

   // Starts a run on dut_a and waits for done; elapsed = clocks from start
   // edge to done edge, -1 on timeout.
   task automatic run_a(input bit hold_start, output int elapsed);
      int last_v;
      vseq.delete();
      busy_gap = 0;
      last_v = -1;
      elapsed = -1;
      @(negedge clk);
      ifa.start = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (!hold_start) ifa.start = 1'b0;
         if (ifa.done) begin elapsed = n - 1; break; end
         if (!ifa.busy) busy_gap++;
         if (int'(ifa.vec_idx) != last_v) begin
            last_v = int'(ifa.vec_idx);
            vseq.push_back(last_v);
         end
      end
      ifa.start = 1'b0;
   endtask

   bit bc_fin = 0;

   initial begin : bc_proc
      int n;
      ifb.q_in = 1'b0; ifb.q_bar_in = 1'b1; ifb.start = 1'b0;
      ifc.q_in = 1'b0; ifc.q_bar_in = 1'b1; ifc.start = 1'b0;
      repeat (4) @(negedge clk);
      ifb.start = 1'b1; ifc.start = 1'b1;
      @(negedge clk);
      ifb.start = 1'b0; ifc.start = 1'b0;
      n = 1;
      while (!ifb.done && n < 300) begin @(negedge clk); n++; end
      chk("b_elapsed", n - 1, 80);
      chk("b_err_stuck0_2pass", int'(ifb.err_count), 4);
      chk("b_pass", int'(ifb.pass), 0);
      while (!ifc.done && n < 3000) begin @(negedge clk); n++; end
      chk("c_elapsed", n - 1, 800);
      chk("c_err_saturated", int'(ifc.err_count), 255);
      chk("c_pass", int'(ifc.pass), 0);
      chk("c_done", int'(ifc.done), 1);
      bc_fin = 1;
   end

   initial begin : main
      int el;
      int k;
      ifa.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(ifa.busy), 0);
      chk("rst_err", int'(ifa.err_count), 0);
      chk("rst_de", int'({ifa.e_out, ifa.d_out}), 0);
      rst_n_a = 1'b1;
      rst_n_bc = 1'b1;
      repeat (2) @(negedge clk);

      fmode = 0;
      run_a(1'b0, el);
      chk("ideal_elapsed", el, 40);
      chk("ideal_err", int'(ifa.err_count), 0);
      chk("ideal_pass", int'(ifa.pass), 1);
      chk("ideal_vseq_len", vseq.size(), 4);
      for (int i = 0; i < 4; i++)
         chk("ideal_vseq", (i < vseq.size()) ? vseq[i] : -1, i);

      fmode = 1;
      run_a(1'b0, el);
      chk("stuck0_err", int'(ifa.err_count), 1);
      chk("stuck0_model", m_err, 1);
      chk("stuck0_pass", int'(ifa.pass), 0);

      fmode = 2;
      run_a(1'b0, el);
      chk("tie_err", int'(ifa.err_count), 2);
      chk("tie_pass", int'(ifa.pass), 0);

      fmode = 0;
      run_a(1'b1, el);
      chk("held_elapsed", el, 40);
      chk("held_no_restart", busy_gap, 0);
      repeat (3) @(negedge clk);
      chk("held_done_stays", int'(ifa.done), 1);
      chk("held_pass", int'(ifa.pass), 1);

      // Reset pulse at clock 15 of a run.
      fmode = 3;
      @(negedge clk);
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      repeat (14) @(negedge clk);
      #2 rst_n_a = 1'b0;
      #1;
      chk("abort_busy", int'(ifa.busy), 0);
      chk("abort_done", int'(ifa.done), 0);
      chk("abort_err", int'(ifa.err_count), 0);
      chk("abort_vec", int'(ifa.vec_idx), 0);
      chk("abort_de", int'({ifa.e_out, ifa.d_out}), 0);
      chk("abort_pass", int'(ifa.pass), 0);
      @(negedge clk);
      rst_n_a = 1'b1;
      fmode = 0;
      run_a(1'b0, el);
      chk("after_abort_err", int'(ifa.err_count), 0);
      chk("after_abort_pass", int'(ifa.pass), 1);

      // Randomized runs; checked cycle by cycle against the model.
      for (int r = 0; r < 25; r++) begin
         fmode = int'($urandom_range(0, 3));
         repeat ($urandom_range(0, 4)) @(negedge clk);
         ifa.start = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         ifa.start = 1'b0;
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 35)) @(negedge clk);
            #2 rst_n_a = 1'b0;
            @(negedge clk);
            rst_n_a = 1'b1;
         end else begin
            k = 0;
            while (!ifa.done && k < 200) begin @(negedge clk); k++; end
            chk("rand_done_seen", int'(ifa.done), 1);
         end
      end

      k = 0;
      while (!bc_fin && k < 3000) begin @(negedge clk); k++; end
      chk("bc_finished", int'(bc_fin), 1);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/dlatch_exerciser.md
# dlatch_exerciser

Self-checking stimulus/monitor stage wrapped directly around the `D_latch` cell. It drives the latch's `d`/`e` inputs through every `{e,d}` combination, holding each combination for a programmable number of clocks. Before each step, it samples `q`/`q_bar` against an internal reference model and counts mismatches. The result is a synthesizable, clocked replacement for the delay-driven sweep, usable on-chip or in a bench.

## Interface
Parameters:
- `HOLD_CYCLES`, default 10: clocks each `{e,d}` vector is held. Must be at least 2.
- `NUM_PASSES`, default 1: full 4-vector sweeps per run. Must be at least 1.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; starts a run when the block is idle or done.
- `d_out`  out  1  drives latch `d`.
- `e_out`  out  1  drives latch `e`.
- `q_in`  in  1  from latch `q`.
- `q_bar_in`  in  1  from latch `q_bar`.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until the next accepted `start` or reset.
- `pass`  out  1  1 when `done` and `err_count == 0`; 0 otherwise.
- `err_count`  out  8  mismatch count; saturates at 255.
- `vec_idx`  out  2  index of the current vector within the sweep.

## Operation
- FSM states: IDLE → RUN → DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE after the last sample of the last pass.
  - DONE → RUN on `start`; this clears `err_count`, `pass` and the model.
- In RUN:
  - `{e_out,d_out}` = vector[`vec_idx`].
  - `hold_cnt` counts from 0 to `HOLD_CYCLES`-1.
  - At `hold_cnt == HOLD_CYCLES-1` the sample/check occurs, then `vec_idx` advances.
  - `vec_idx` wraps from 3 to 0 and increments `pass_cnt`, which is `$clog2(NUM_PASSES+1)` bits wide.
- Reference model:
  - `exp_q` and `exp_valid` are cleared on run start.
  - On each sample with `e_out=1`: `exp_q <= d_out` and `exp_valid <= 1`.
  - With `e_out=0`: `exp_q` holds.
  - The check compares `q_in` against the current-vector expectation: `d_out` if `e_out=1`, else `exp_q`.
- A check fires only when the expectation is defined, i.e. `e_out=1` or `exp_valid=1`. A mismatch is either of:
  - `q_in` differs from the expectation;
  - `q_bar_in` does not equal `~q_in`.
- Each mismatch adds exactly 1, even when both conditions fail. X or Z on `q_in`/`q_bar_in` counts as a mismatch (case-inequality).
- `start` while `busy` is ignored.
- Outputs in IDLE: `d_out=0`, `e_out=0`.

## Timing
- Reset values (asynchronous): state IDLE, all of these 0:
  - outputs: `d_out`, `e_out`, `busy`, `done`, `pass`, `err_count`, `vec_idx`;
  - internal: `hold_cnt`, `pass_cnt`, `exp_q`, `exp_valid`.
- Reset asserted mid-run aborts immediately. No partial result is kept.
- `start` is high at edge N: `busy=1` and vector 0 are driven after edge N.
- Each vector occupies exactly `HOLD_CYCLES` clocks. The sample uses the values present at the last edge of the window.
- `busy` falls and `done` rises on the edge of the final sample. That is `4*HOLD_CYCLES*NUM_PASSES` clocks after the start edge.
- `err_count` updates on the sample edge. `pass` is registered together with `done`.
- Saturation: once `err_count` is 255 it stays 255.

## Configuration
- `DLATCH_EXER_GRAY_EN`:
  - Defined: sweep order is Gray (00, 01, 11, 10), so only one of `e`/`d` toggles per step.
  - Undefined: binary order (00, 01, 10, 11), matching the existing sweep.
- The macro changes only vector order. Counting and timing rules are identical in both modes.

## Test plan
- Ideal behavioural latch, `HOLD_CYCLES`=10, `NUM_PASSES`=1, binary order → `done` 40 clocks after start, `err_count`=0, `pass`=1, `vec_idx` seen in order 0, 1, 2, 3.
- `q_in` stuck at 0, `q_bar_in`=1, binary order:
  - `NUM_PASSES`=1 → `err_count`=1 (vector 11).
  - `NUM_PASSES`=2 → `err_count`=4.
  - Gray order, 1 pass → `err_count`=1.
- `q_bar_in` tied to `q_in` with an ideal latch, 1 pass, binary order → `err_count`=2 (both checked vectors), `pass`=0.
- `rst_n` pulsed low at clock 15 of a run:
  - all outputs 0 asynchronously and state IDLE;
  - a new `start` completes a clean run with `err_count`=0.
- `start` held high during the whole run → no restart while `busy`; `done` appears exactly once at 40 clocks.
- `HOLD_CYCLES`=2, `NUM_PASSES`=100, `q_in` stuck at 0 → raw count 298, `err_count` saturates at 255, `pass`=0.
